// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and error codes.
package program_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHK_HI,
    ST_CHK_LO,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_LENGTH   = 2'd3;

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte timeout for the loader: loadable down-counter, expire flags the last allowed idle cycle.
module program_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Fires on the idle cycle that would bring the elapsed count up to TIMEOUT_CYCLES.
  assign expire = count_en && !load && (cnt_q == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program image from a byte link into
// program memory while holding the CPU in reset.
//
// state    | meaning
// IDLE     | after reset, CPU held in reset, waiting for start
// LEN_HI   | waiting for high byte of word count
// LEN_LO   | waiting for low byte of word count, length checked on accept
// DATA_HI  | waiting for high byte of next data word
// DATA_LO  | waiting for low byte of next data word
// WRITE    | one-cycle write strobe to program memory
// CHK_HI   | waiting for high byte of checksum
// CHK_LO   | waiting for low byte of checksum, compared on accept
// DONE     | image loaded, CPU released
// ERROR    | load failed, error code held, CPU held in reset
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data_in,
  output logic                  mem_write_enable,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned RW        = ADDR_WIDTH + 1;

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]         remaining_q, remaining_d;
  logic [15:0]           chk_q, chk_d;
  logic [15:0]           word_q, word_d;
  logic [7:0]            hi_q, hi_d;
  logic [1:0]            err_q, err_d;

  logic        xfer, idle_like, start_load, to_load, to_count, to_expire;
  logic [15:0] rx_word;

  assign rx_ready   = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
                                      ST_DATA_LO, ST_CHK_HI, ST_CHK_LO};
  assign xfer       = rx_valid && rx_ready;
  assign idle_like  = state_q inside {ST_IDLE, ST_DONE, ST_ERROR};
  assign start_load = start && idle_like;
  assign rx_word    = {hi_q, rx_data};
  assign to_load    = xfer || start_load;
  assign to_count   = rx_ready && !xfer;

  program_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .load     (to_load),
    .count_en (to_count),
    .expire   (to_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    chk_d       = chk_q;
    word_d      = word_q;
    hi_d        = hi_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LEN_HI;
          addr_d      = '0;
          remaining_d = '0;
          chk_d       = '0;
          err_d       = ERR_NONE;
        end
      end
      ST_LEN_HI, ST_DATA_HI, ST_CHK_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = loader_state_e'(state_q + 4'd1);
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (32'(rx_word) > MAX_WORDS) begin
            state_d = ST_ERROR;
            err_d   = ERR_LENGTH;
          end else if (rx_word == 16'd0) begin
            state_d = ST_CHK_HI;
          end else begin
            state_d     = ST_DATA_HI;
            remaining_d = RW'(rx_word);
          end
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          word_d  = rx_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        chk_d       = chk_q ^ word_q;
        remaining_d = remaining_q - RW'(1);
        state_d     = (remaining_q == RW'(1)) ? ST_CHK_HI : ST_DATA_HI;
      end
      ST_CHK_LO: begin
        if (xfer) begin
          if (rx_word == chk_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CHECKSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only asserted in receive states without a transfer, so an accepted byte always wins.
    if (to_expire) begin
      state_d = ST_ERROR;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      chk_q       <= '0;
      word_q      <= '0;
      hi_q        <= '0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      chk_q       <= chk_d;
      word_q      <= word_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
    end
  end

  assign mem_address      = addr_q;
  assign mem_data_in      = word_q;
  assign mem_write_enable = (state_q == ST_WRITE);
  assign cpu_reset        = (state_q != ST_DONE);
  assign busy             = !idle_like;
  assign done             = (state_q == ST_DONE);
  assign error            = err_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: streams a program image from a byte source into program memory.
- Holds the CPU in reset while it loads, then releases the CPU.
- Sits between a byte receiver (UART/debug link) and the write port of the program memory instance.
- Word format is the 16-bit instruction word (func|src1|src2|dest). Bytes arrive high byte first.

Parameters:
ADDR_WIDTH, 12, program memory address width (matches the 12-bit program counter).
TIMEOUT_CYCLES, 65535, cycles allowed between accepted bytes before a timeout error.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (low = reset).
start  in  1  one-cycle request to begin a load.
rx_data  in  8  incoming byte.
rx_valid  in  1  rx_data is valid.
rx_ready  out  1  loader can accept a byte; a byte is transferred when rx_valid && rx_ready at posedge.
mem_address  out  ADDR_WIDTH  program memory write address.
mem_data_in  out  16  program memory write data.
mem_write_enable  out  1  one-cycle write strobe.
cpu_reset  out  1  active-high reset to the CPU core.
busy  out  1  load in progress.
done  out  1  last load succeeded; CPU is running.
error  out  2  0 = none, 1 = timeout, 2 = checksum mismatch, 3 = length overflow.

Behaviour:
- Reset values: state IDLE, cpu_reset=1, rx_ready=0, mem_write_enable=0, mem_address=0, mem_data_in=0, busy=0, done=0, error=0. All internal counters and the checksum are cleared.
- Stream format: LEN_HI, LEN_LO, N x (DATA_HI, DATA_LO), CHK_HI, CHK_LO.
  - N = {LEN_HI, LEN_LO}.
  - The checksum is the XOR of all N data words.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, DONE, ERROR.
- IDLE/DONE/ERROR with start=1:
  - Next cycle enter LEN_HI.
  - cpu_reset=1, busy=1, done=0, error=0.
  - Address, checksum and timeout counters cleared.
- start while busy is ignored.
- rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO. Each accepted byte advances the state by one.
- LEN_LO accept, with N = {LEN_HI, LEN_LO}:
  - If N > 2**ADDR_WIDTH, go to ERROR with error=3.
  - Else if N == 0, go to CHK_HI.
  - Else go to DATA_HI, with remaining = N.
- DATA_LO accept: word = {hi, lo}; go to WRITE.
- WRITE lasts exactly one cycle:
  - mem_write_enable=1, mem_address=current address, mem_data_in=word, rx_ready=0.
  - On exit: address+1 (wraps modulo 2**ADDR_WIDTH; wrap only occurs after the final word when N = 2**ADDR_WIDTH), checksum ^= word, remaining-1.
  - Go to CHK_HI if remaining becomes 0, else DATA_HI.
- mem_write_enable is 0 in every state other than WRITE.
- CHK_LO accept:
  - If {hi, lo} == checksum, go to DONE.
  - Otherwise go to ERROR with error=2.
- DONE: cpu_reset=0, done=1, busy=0.
- ERROR: cpu_reset=1, busy=0, done=0. error holds its code until the next start or reset.
- Timeout:
  - The counter increments each cycle in a rx_ready state without a transfer. It clears on transfer and on state entry from IDLE/DONE/ERROR.
  - When the count reaches TIMEOUT_CYCLES, go to ERROR with error=1.
  - A transfer in the same cycle wins over the timeout.
- Latency: the write strobe occurs 1 cycle after the DATA_LO transfer. DONE is entered 1 cycle after the CHK_LO transfer.
- Reset mid-load returns to the reset values immediately. Words already written stay in memory; cpu_reset stays 1.
- rx_valid gaps of any length shorter than the timeout are tolerated.

Decomposition:
- Shared package: loader state encoding, error code constants (ERR_NONE, ERR_TIMEOUT, ERR_CHECKSUM, ERR_LENGTH).
- Natural sub-module: loader_timeout, a loadable/clearable down-counter that raises an expire flag. Everything else stays in one FSM module.

Test Plan (bench uses TIMEOUT_CYCLES=16 for the timeout case):
1. Normal load: stream 00 03 12 34 AB CD 0F 0F B6 F6 with gapped rx_valid.
   - Expect exactly 3 write strobes: (0,0x1234), (1,0xABCD), (2,0x0F0F).
   - Then done=1, cpu_reset=0, error=0, busy=0.
2. Checksum fail: same stream ending B6 F7.
   - Expect the 3 writes, then error=2, cpu_reset=1, done=0.
3. Empty image: stream 00 00 00 00.
   - Expect no write strobes, done=1, cpu_reset=0.
4. Timeout: stream 00 02 12, then hold rx_valid=0.
   - Expect error=1 after 16 idle cycles, no write strobe, cpu_reset=1.
5. Length overflow: stream 10 01.
   - Expect error=3 one cycle after the second byte, rx_ready=0, no writes.
6. Reset and restart:
   - Assert reset low during the DATA_LO of word 2: all outputs return to reset values asynchronously.
   - Release reset, pulse start, rerun case 1: it passes.
   - A start pulse while busy has no effect.
